// File: rtl/logicunit_bist_pkg.sv
// Shared definitions for the logic-unit BIST controller: op codes, LFSR polynomial,
// FSM state encoding and the Galois step used by every LFSR/MISR instance.
package logicunit_bist_pkg;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_NOR = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  // x^32 + x^22 + x^2 + x + 1 as a right-shifting Galois tap mask
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [31:0] galois_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/logicunit_bist_lfsr32_galois.sv
// 32-bit right-shift Galois LFSR with seed load and step enable; the xin port
// folds data into the feedback so the same block serves as a MISR.
module lfsr32_galois
  import logicunit_bist_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  input  logic [31:0] xin,
  output logic [31:0] state
);

  always_ff @(posedge clock) begin
    if (!reset || load) begin
      state <= seed;
    end else if (step) begin
      state <= galois_step(state) ^ xin;
    end
  end

endmodule

// File: rtl/logicunit_bist.sv
// BIST controller driving a combinational AND/OR/NOR/XOR logic unit with LFSR
// operands and checking every result. Define LOGICUNIT_BIST_MISR_EN for the MISR signature.
module logicunit_bist
  import logicunit_bist_pkg::*;
#(
  parameter int          WIDTH   = 32,
  parameter int          VECTORS = 256,
  parameter logic [31:0] SEED_A  = 32'hACE1_2468,
  parameter logic [31:0] SEED_B  = 32'h1357_9BDF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [1:0]       control,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [1:0]       first_fail_op,
  output logic [15:0]      first_fail_vec,
  output logic [31:0]      signature
);

  localparam logic [15:0] LAST_IDX = 16'(VECTORS - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t           state, state_nxt;
  logic             run_load, run_step, last_vec, mismatch;
  logic [15:0]      idx;
  logic [WIDTH-1:0] gold;
  logic [31:0]      a_lfsr, b_lfsr, a_nxt, b_nxt;

  lfsr32_galois u_lfsr_a (
    .clock(clock), .reset(reset), .load(run_load), .step(run_step),
    .seed(SEED_A), .xin(32'h0), .state(a_lfsr)
  );

  lfsr32_galois u_lfsr_b (
    .clock(clock), .reset(reset), .load(run_load), .step(run_step),
    .seed(SEED_B), .xin(32'h0), .state(b_lfsr)
  );

  // A/B registers run in lockstep with the LFSRs but are cleared by reset
  assign a_nxt = galois_step(a_lfsr);
  assign b_nxt = galois_step(b_lfsr);

  always_comb begin
    gold = A ^ B;
    case (control)
      OP_AND:  gold = A & B;
      OP_OR:   gold = A | B;
      OP_NOR:  gold = ~(A | B);
      default: gold = A ^ B;
    endcase
  end

  assign mismatch = (dut_out != gold);
  assign last_vec = (control == OP_XOR) && (idx == LAST_IDX);
  assign pass     = done && (err_count == 16'h0);

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_vec) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    run_load = 1'b0;
    run_step = 1'b0;
    case (state)
      IDLE: run_load = start;
      RUN: begin
        busy     = 1'b1;
        run_step = 1'b1;
      end
      DONE: begin
        done     = 1'b1;
        run_load = start;
      end
      default: ;
    endcase
  end

  // Final vector leaves A/B/control on the last applied values for DONE
  always_ff @(posedge clock) begin
    if (!reset) begin
      A              <= '0;
      B              <= '0;
      control        <= OP_AND;
      idx            <= '0;
      err_count      <= '0;
      first_fail_op  <= '0;
      first_fail_vec <= '0;
    end else if (run_load) begin
      A              <= SEED_A[WIDTH-1:0];
      B              <= SEED_B[WIDTH-1:0];
      control        <= OP_AND;
      idx            <= '0;
      err_count      <= '0;
      first_fail_op  <= '0;
      first_fail_vec <= '0;
    end else if (run_step) begin
      if (mismatch) begin
        err_count <= sat_inc(err_count);
        if (err_count == 16'h0) begin
          first_fail_op  <= control;
          first_fail_vec <= idx;
        end
      end
      if (!last_vec) begin
        A <= a_nxt[WIDTH-1:0];
        B <= b_nxt[WIDTH-1:0];
        if (idx == LAST_IDX) begin
          idx     <= '0;
          control <= control + 2'd1;
        end else begin
          idx <= idx + 16'd1;
        end
      end
    end
  end

`ifdef LOGICUNIT_BIST_MISR_EN
  logic [31:0] dut_ext;
  assign dut_ext = 32'(dut_out);

  lfsr32_galois u_misr (
    .clock(clock), .reset(reset), .load(run_load), .step(run_step),
    .seed(32'h0), .xin(dut_ext), .state(signature)
  );
`else
  assign signature = 32'h0;
`endif

endmodule

// File: tb/tb_logicunit_bist.sv
// Scoreboard bench for logicunit_bist: a behavioural logic unit with selectable
// faults, directed runs with hand-computed results, and a saturation run.
module tb_logicunit_bist;

  localparam int V = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, start, start_s;
  logic [31:0] A, B, dut_out, signature;
  logic [1:0]  control, ffop;
  logic        busy, done, pass;
  logic [15:0] err_count, ffvec;
  int          mode;

  logic [7:0]  A_s, B_s, dut_out_s;
  logic [1:0]  control_s, ffop_s;
  logic        busy_s, done_s, pass_s;
  logic [15:0] err_s, ffvec_s;
  logic [31:0] sig_s, t_s;

  logicunit_bist #(.WIDTH(32), .VECTORS(V)) u_dut (
    .clock(clock), .reset(reset), .start(start), .A(A), .B(B), .control(control),
    .dut_out(dut_out), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_op(ffop), .first_fail_vec(ffvec), .signature(signature)
  );

  logicunit_bist #(.WIDTH(8), .VECTORS(16384)) u_sat (
    .clock(clock), .reset(reset), .start(start_s), .A(A_s), .B(B_s), .control(control_s),
    .dut_out(dut_out_s), .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s),
    .first_fail_op(ffop_s), .first_fail_vec(ffvec_s), .signature(sig_s)
  );

  function automatic logic [31:0] lu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c);
    case (c)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  // Logic unit under test: 0 healthy, 1 XOR bit0 flipped, 2 NOR acts as OR, 3 inverted
  always_comb begin
    case (mode)
      1:       dut_out = (control == 2'd3) ? (lu(A, B, control) ^ 32'h1) : lu(A, B, control);
      2:       dut_out = (control == 2'd2) ? (A | B) : lu(A, B, control);
      3:       dut_out = ~lu(A, B, control);
      default: dut_out = lu(A, B, control);
    endcase
  end

  assign t_s       = lu(32'(A_s), 32'(B_s), control_s);
  assign dut_out_s = ~t_s[7:0];

  typedef struct { logic [31:0] a; logic [31:0] b; logic [1:0] c; } vec_t;
  typedef struct { logic [15:0] err; logic [1:0] op; logic [15:0] vec; logic p; int len; } res_t;

  vec_t vq[$];
  res_t rq[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  logic busy_q = 1'b0;
  logic done_q = 1'b0;
  int   blen   = 0;

  always @(negedge clock) begin
    vec_t v;
    res_t r;
    if (busy) begin
      blen = busy_q ? blen + 1 : 1;
      if (vq.size() > 0) begin
        v = vq.pop_front();
        chk("vec_a", A, v.a);
        chk("vec_b", B, v.b);
        chk("vec_ctl", 32'(control), 32'(v.c));
      end
    end
    if (done && !done_q) begin
      if (rq.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'h0);
      end else begin
        r = rq.pop_front();
        chk("err_count", 32'(err_count), 32'(r.err));
        chk("first_fail_op", 32'(ffop), 32'(r.op));
        chk("first_fail_vec", 32'(ffvec), 32'(r.vec));
        chk("pass", 32'(pass), 32'(r.p));
        chk("run_cycles", 32'(blen), 32'(r.len));
        chk("done_ctl", 32'(control), 32'h3);
      end
    end
    busy_q = busy;
    done_q = done;
  end

  // First three vectors of any run: seeds, then two Galois steps (all op 0)
  task automatic push_vecs();
    vq.push_back('{32'hACE1_2468, 32'h1357_9BDF, 2'd0});
    vq.push_back('{32'h5670_9234, 32'h898B_CDEC, 2'd0});
    vq.push_back('{32'h2B38_491A, 32'h44C5_E6F6, 2'd0});
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic run_main(input int m, input logic [15:0] e_err, input logic [1:0] e_op,
                          input logic [15:0] e_vec, input logic e_pass, input int pulse_at);
    mode = m;
    push_vecs();
    rq.push_back('{e_err, e_op, e_vec, e_pass, 4 * V});
    pulse_start();
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      start = (i == pulse_at);
      if (done) break;
    end
    start = 1'b0;
    if (!done) begin
      $display("FAIL run_timeout: got done=%0b, expected 1", done);
      $fatal(1);
    end
    repeat (2) @(negedge clock);
  endtask

  logic [31:0] sig1, sig_fault;
  int          cnt;

  initial begin
    reset = 1'b0; start = 1'b0; start_s = 1'b0; mode = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_pass", 32'(pass), 32'h0);
    chk("rst_err", 32'(err_count), 32'h0);
    chk("rst_ffvec", 32'(ffvec), 32'h0);
    chk("rst_a", A, 32'h0);
    chk("rst_b", B, 32'h0);
    chk("rst_sig", signature, 32'h0);
    start = 1'b1;
    @(posedge clock); #1;
    chk("start_in_reset_busy", 32'(busy), 32'h0);
    start = 1'b0;
    reset = 1'b1;

    run_main(0, 16'd0, 2'd0, 16'd0, 1'b1, 5);
    sig1 = signature;
`ifdef LOGICUNIT_BIST_MISR_EN
    chk("sig_nonzero", 32'(signature != 32'h0), 32'h1);
`else
    chk("sig_tied_zero", signature, 32'h0);
`endif
    run_main(1, 16'd4, 2'd3, 16'd0, 1'b0, -1);
    sig_fault = signature;
    run_main(2, 16'd4, 2'd2, 16'd0, 1'b0, -1);
    run_main(3, 16'd16, 2'd0, 16'd0, 1'b0, -1);

    mode = 3;
    push_vecs();
    pulse_start();
    repeat (10) @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_err", 32'(err_count), 32'h0);
    chk("midrst_a", A, 32'h0);
    chk("midrst_b", B, 32'h0);
    chk("midrst_ctl", 32'(control), 32'h0);
    chk("midrst_ffvec", 32'(ffvec), 32'h0);
    reset = 1'b1;

    run_main(0, 16'd0, 2'd0, 16'd0, 1'b1, -1);
`ifdef LOGICUNIT_BIST_MISR_EN
    chk("sig_repeat", signature, sig1);
    chk("sig_fault_differs", 32'(sig_fault != sig1), 32'h1);
`else
    chk("sig_fault_zero", sig_fault, 32'h0);
`endif

    // Saturation: 65536 inverted results, with start pulses mid-run
    @(posedge clock); #1 start_s = 1'b1;
    @(posedge clock); #1 start_s = 1'b0;
    cnt = 0;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clock);
      if (done_s) break;
      if (busy_s) cnt++;
      start_s = (cnt == 100) || (cnt == 30000);
    end
    start_s = 1'b0;
    chk("sat_done", 32'(done_s), 32'h1);
    chk("sat_run_cycles", 32'(cnt), 32'd65536);
    chk("sat_err", 32'(err_s), 32'h0000_FFFF);
    chk("sat_pass", 32'(pass_s), 32'h0);
    chk("sat_ffop", 32'(ffop_s), 32'h0);
    chk("sat_ffvec", 32'(ffvec_s), 32'h0);
    chk("sat_ctl", 32'(control_s), 32'h3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
